// File: rtl/mmu_pkg.sv
// Shared widths, FSM state encoding and TLB entry layout for mmu_tlb and tlb_cam.
package mmu_pkg;

    localparam int VA_W  = 14;
    localparam int OFF_W = 5;
    localparam int VPN_W = VA_W - OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WALK   = 2'd2,
        ST_RESP   = 2'd3
    } tlb_state_e;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] tag;
        logic [VPN_W-1:0] ppn;
    } tlb_entry_t;

endpackage

// File: rtl/mmu_tlb_cam.sv
// tlb_cam: combinational tag compare across all TLB entries, plus first-invalid search.
module tlb_cam
    import mmu_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  tlb_entry_t [ENTRIES-1:0] in_entries,
    input  logic [VPN_W-1:0]         in_vpn,
    output logic [ENTRIES-1:0]       out_match,
    output logic                     out_hit,
    output logic [VPN_W-1:0]         out_ppn,
    output logic [IDX_W-1:0]         out_first_inv,
    output logic                     out_any_invalid
);

    always_comb begin
        out_match       = '0;
        out_ppn         = '0;
        out_first_inv   = '0;
        out_any_invalid = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            out_match[i] = in_entries[i].valid && (in_entries[i].tag == in_vpn);
            // Matches are one-hot, so OR-ing the gated ppns acts as a mux.
            out_ppn = out_ppn | (in_entries[i].ppn & {VPN_W{out_match[i]}});
            if (!in_entries[i].valid && !out_any_invalid) begin
                out_first_inv   = IDX_W'(i);
                out_any_invalid = 1'b1;
            end
        end
    end

    assign out_hit = |out_match;

endmodule

// File: rtl/mmu_tlb.sv
// mmu_tlb: fully-associative TLB in front of table_walk; one request outstanding.
// Optional hit/miss counters are built when TLB_STATS_EN is defined.
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_req_valid,
    output logic            out_req_ready,
    input  logic [VA_W-1:0] in_req_mva,
    output logic            out_rsp_valid,
    output logic [VA_W-1:0] out_rsp_paddr,
    output logic            out_rsp_hit,
    output logic            out_walk_en,
    output logic [VA_W-1:0] out_walk_mva,
    input  logic            in_walk_done,
    input  logic [VA_W-1:0] in_walk_paddr,
`ifdef TLB_STATS_EN
    output logic [15:0]     out_hit_cnt,
    output logic [15:0]     out_miss_cnt,
`endif
    input  logic            in_flush
);

    localparam int IDX_W = $clog2(ENTRIES);

    tlb_state_e               state_q, state_d;
    logic [VA_W-1:0]          mva_q, mva_d;
    logic [VA_W-1:0]          rsp_paddr_q, rsp_paddr_d;
    logic                     rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    tlb_entry_t [ENTRIES-1:0] entries_q, entries_d;

    logic [ENTRIES-1:0] cam_match;
    logic               cam_hit;
    logic [VPN_W-1:0]   cam_ppn;
    logic [IDX_W-1:0]   cam_first_inv;
    logic               cam_any_invalid;
    logic               lookup_hit;
    logic [IDX_W-1:0]   victim;
    logic               unused_walk_off;

    tlb_cam #(
        .ENTRIES (ENTRIES)
    ) u_cam (
        .in_entries      (entries_q),
        .in_vpn          (mva_q[VA_W-1:OFF_W]),
        .out_match       (cam_match),
        .out_hit         (cam_hit),
        .out_ppn         (cam_ppn),
        .out_first_inv   (cam_first_inv),
        .out_any_invalid (cam_any_invalid)
    );

    assign lookup_hit      = cam_hit && !in_flush;
    assign unused_walk_off = ^in_walk_paddr[OFF_W-1:0];

    always_comb begin
        state_d     = state_q;
        mva_d       = mva_q;
        rsp_paddr_d = rsp_paddr_q;
        rsp_hit_d   = rsp_hit_q;
        rr_ptr_d    = rr_ptr_q;
        entries_d   = entries_q;
        victim      = '0;
        case (state_q)
            ST_IDLE: begin
                if (in_req_valid) begin
                    mva_d   = in_req_mva;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lookup_hit) begin
                    rsp_paddr_d = {cam_ppn, mva_q[OFF_W-1:0]};
                    rsp_hit_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                if (in_walk_done) begin
                    victim = cam_any_invalid ? cam_first_inv : rr_ptr_q;
                    if (!cam_any_invalid) begin
                        rr_ptr_d = rr_ptr_q + 1'b1;
                    end
                    entries_d[victim].valid = 1'b1;
                    entries_d[victim].tag   = mva_q[VA_W-1:OFF_W];
                    entries_d[victim].ppn   = in_walk_paddr[VA_W-1:OFF_W];
                    rsp_paddr_d = {in_walk_paddr[VA_W-1:OFF_W], mva_q[OFF_W-1:0]};
                    rsp_hit_d   = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Applied after the fill so a simultaneous flush leaves the new entry invalid.
        if (in_flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entries_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= ST_IDLE;
            mva_q       <= '0;
            rsp_paddr_q <= '0;
            rsp_hit_q   <= 1'b0;
            rr_ptr_q    <= '0;
            entries_q   <= '0;
        end else begin
            state_q     <= state_d;
            mva_q       <= mva_d;
            rsp_paddr_q <= rsp_paddr_d;
            rsp_hit_q   <= rsp_hit_d;
            rr_ptr_q    <= rr_ptr_d;
            entries_q   <= entries_d;
        end
    end

    assign out_req_ready = (state_q == ST_IDLE);
    assign out_walk_en   = (state_q == ST_WALK);
    assign out_walk_mva  = out_walk_en ? mva_q : '0;
    assign out_rsp_valid = (state_q == ST_RESP);
    assign out_rsp_paddr = rsp_paddr_q;
    assign out_rsp_hit   = rsp_hit_q;

    a_match_onehot: assert property (@(posedge in_clk) disable iff (in_rst) $onehot0(cam_match));

`ifdef TLB_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == ST_LOOKUP) begin
            if (lookup_hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign out_hit_cnt  = hit_cnt_q;
    assign out_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed self-checking bench for mmu_tlb; stats checks are built when TLB_STATS_EN is defined.
module tb_mmu_tlb;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_req_valid = 1'b0;
    logic        out_req_ready;
    logic [13:0] in_req_mva = '0;
    logic        out_rsp_valid;
    logic [13:0] out_rsp_paddr;
    logic        out_rsp_hit;
    logic        out_walk_en;
    logic [13:0] out_walk_mva;
    logic        in_walk_done = 1'b0;
    logic [13:0] in_walk_paddr = '0;
    logic        in_flush = 1'b0;
`ifdef TLB_STATS_EN
    logic [15:0] out_hit_cnt;
    logic [15:0] out_miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cycle_ctr = 0;

    mmu_tlb #(.ENTRIES(8)) dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_req_valid  (in_req_valid),
        .out_req_ready (out_req_ready),
        .in_req_mva    (in_req_mva),
        .out_rsp_valid (out_rsp_valid),
        .out_rsp_paddr (out_rsp_paddr),
        .out_rsp_hit   (out_rsp_hit),
        .out_walk_en   (out_walk_en),
        .out_walk_mva  (out_walk_mva),
        .in_walk_done  (in_walk_done),
        .in_walk_paddr (in_walk_paddr),
`ifdef TLB_STATS_EN
        .out_hit_cnt   (out_hit_cnt),
        .out_miss_cnt  (out_miss_cnt),
`endif
        .in_flush      (in_flush)
    );

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cycle_ctr++;

    task automatic do_reset();
        in_rst = 1'b1; in_req_valid = 1'b0; in_walk_done = 1'b0; in_flush = 1'b0;
        repeat (2) @(negedge in_clk);
        in_rst = 1'b0;
        @(negedge in_clk);
    endtask

    // Drives one request and plays table_walk; cycle numbers count from the handshake edge.
    task automatic transact(input logic [13:0] mva, input logic [13:0] wpaddr, input int walk_lat,
                            input logic flush_lookup, input logic flush_done,
                            output logic hit, output logic [13:0] paddr,
                            output int walk_cyc, output int rsp_cyc, output logic [13:0] wmva);
        int cyc;
        logic got;
        @(negedge in_clk);
        in_req_valid = 1'b1; in_req_mva = mva;
        @(posedge in_clk);
        cyc = 0; got = 1'b0; walk_cyc = -1; rsp_cyc = -1; hit = 1'b0; paddr = '0; wmva = '0;
        while (!got && cyc < 60) begin
            @(negedge in_clk);
            cyc++;
            in_req_valid = 1'b0; in_walk_done = 1'b0; in_flush = 1'b0;
            if (cyc == 1) in_flush = flush_lookup;
            if (out_walk_en && walk_cyc < 0) begin walk_cyc = cyc; wmva = out_walk_mva; end
            if (out_walk_en && cyc >= walk_cyc + walk_lat) begin
                in_walk_done = 1'b1; in_walk_paddr = wpaddr; in_flush = flush_done;
            end
            if (out_rsp_valid) begin got = 1'b1; rsp_cyc = cyc; paddr = out_rsp_paddr; hit = out_rsp_hit; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", out_req_ready); end
        checks++; if (out_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", out_rsp_valid); end
        checks++; if (out_walk_en !== 1'b0) begin errors++; $display("FAIL reset_walk_en: got %b expected 0", out_walk_en); end
        checks++; if ({out_rsp_paddr, out_rsp_hit, out_walk_mva} !== 29'd0) begin errors++;
            $display("FAIL reset_outputs: got paddr=%h hit=%b walk_mva=%h expected all 0", out_rsp_paddr, out_rsp_hit, out_walk_mva); end
    endtask

    task automatic test_cold_miss_rehit();
        logic hit; logic [13:0] pa, wm; int wc, rc;
        transact(14'h01A5, 14'h3E60, 2, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        checks++; if (wc !== 2) begin errors++; $display("FAIL cold_walk_cycle: got %0d expected 2", wc); end
        checks++; if (wm !== 14'h01A5) begin errors++; $display("FAIL cold_walk_mva: got %h expected 01a5", wm); end
        checks++; if (rc !== 5) begin errors++; $display("FAIL cold_rsp_cycle: got %0d expected 5", rc); end
        checks++; if ({pa, hit} !== {14'h3E65, 1'b0}) begin errors++; $display("FAIL cold_rsp: got paddr=%h hit=%b expected 3e65/0", pa, hit); end
        transact(14'h01A5, 14'h0000, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        checks++; if (rc !== 2) begin errors++; $display("FAIL rehit_rsp_cycle: got %0d expected 2", rc); end
        checks++; if (wc !== -1) begin errors++; $display("FAIL rehit_walk: got walk cycle %0d expected none", wc); end
        checks++; if ({pa, hit} !== {14'h3E65, 1'b1}) begin errors++; $display("FAIL rehit_rsp: got paddr=%h hit=%b expected 3e65/1", pa, hit); end
        @(negedge in_clk);
        checks++; if ({out_rsp_valid, out_rsp_paddr, out_rsp_hit} !== {1'b0, 14'h3E65, 1'b1}) begin errors++;
            $display("FAIL rsp_hold: got valid=%b paddr=%h hit=%b expected 0/3e65/1", out_rsp_valid, out_rsp_paddr, out_rsp_hit); end
    endtask

    task automatic test_back_to_back();
        logic hit; logic [13:0] pa, wm; int wc, rc, t0, t1;
        transact(14'h01A5, 14'h0000, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        t0 = cycle_ctr;
        for (int k = 0; k < 2; k++) begin
            transact(14'h01A5, 14'h0000, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
            t1 = cycle_ctr;
            checks++; if ((t1 - t0) !== 3 || hit !== 1'b1) begin errors++;
                $display("FAIL b2b_spacing: got %0d cycles hit=%b expected 3/1", t1 - t0, hit); end
            t0 = t1;
        end
    endtask

    task automatic test_replacement();
        logic hit; logic [13:0] pa, wm; int wc, rc;
        logic [8:0] vv;
        do_reset();
        for (int v = 0; v < 9; v++) begin
            vv = 9'(v);
            transact({vv, 5'h03}, {vv + 9'h100, 5'h1F}, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
            checks++; if ({pa, hit} !== {vv + 9'h100, 5'h03, 1'b0}) begin errors++;
                $display("FAIL fill_vpn%0d: got paddr=%h hit=%b expected %h/0", v, pa, hit, {vv + 9'h100, 5'h03}); end
        end
        transact({9'd1, 5'h03}, 14'h0, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        checks++; if ({pa, hit} !== {9'h101, 5'h03, 1'b1}) begin errors++; $display("FAIL vpn1_hit: got paddr=%h hit=%b expected 2023/1", pa, hit); end
        transact({9'd0, 5'h03}, {9'h100, 5'h00}, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        checks++; if (hit !== 1'b0 || wc !== 2) begin errors++; $display("FAIL vpn0_evicted: got hit=%b walk=%0d expected 0/2", hit, wc); end
        transact({9'd2, 5'h03}, 14'h0, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        checks++; if ({pa, hit} !== {9'h102, 5'h03, 1'b1}) begin errors++; $display("FAIL vpn2_hit: got paddr=%h hit=%b expected 2043/1", pa, hit); end
        transact({9'd1, 5'h03}, {9'h101, 5'h00}, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL vpn1_evicted_rr: got hit=%b expected 0", hit); end
    endtask

    task automatic test_flush();
        logic hit; logic [13:0] pa, wm; int wc, rc;
        do_reset();
        transact(14'h01A5, 14'h3E60, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        @(negedge in_clk); in_flush = 1'b1;
        @(negedge in_clk); in_flush = 1'b0;
        transact(14'h01A5, 14'h3E60, 1, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        checks++; if (hit !== 1'b0 || wc !== 2) begin errors++; $display("FAIL flush_idle_miss: got hit=%b walk=%0d expected 0/2", hit, wc); end
        transact(14'h01A5, 14'h3E60, 0, 1'b1, 1'b0, hit, pa, wc, rc, wm);
        checks++; if (hit !== 1'b0 || wc !== 2) begin errors++; $display("FAIL flush_lookup_miss: got hit=%b walk=%0d expected 0/2", hit, wc); end
        @(negedge in_clk); in_flush = 1'b1;
        @(negedge in_clk); in_flush = 1'b0;
        transact(14'h01A5, 14'h3E60, 0, 1'b0, 1'b1, hit, pa, wc, rc, wm);
        checks++; if ({pa, hit} !== {14'h3E65, 1'b0}) begin errors++; $display("FAIL flush_fill_rsp: got paddr=%h hit=%b expected 3e65/0", pa, hit); end
        transact(14'h01A5, 14'h3E60, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        checks++; if (hit !== 1'b0 || wc !== 2) begin errors++; $display("FAIL flush_fill_invalid: got hit=%b walk=%0d expected 0/2", hit, wc); end
    endtask

    task automatic test_reset_mid_walk();
        logic hit; logic [13:0] pa, wm; int wc, rc;
        do_reset();
        @(negedge in_clk); in_req_valid = 1'b1; in_req_mva = 14'h0040;
        @(posedge in_clk);
        @(negedge in_clk); in_req_valid = 1'b0;
        @(negedge in_clk);
        checks++; if (out_walk_en !== 1'b1) begin errors++; $display("FAIL midwalk_started: got walk_en=%b expected 1", out_walk_en); end
        #2 in_rst = 1'b1;
        #1;
        checks++; if ({out_walk_en, out_req_ready, out_rsp_valid} !== 3'b010) begin errors++;
            $display("FAIL midwalk_reset: got walk_en=%b ready=%b rsp_valid=%b expected 0/1/0", out_walk_en, out_req_ready, out_rsp_valid); end
        @(negedge in_clk); in_rst = 1'b0;
        transact(14'h0040, 14'h2A00, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        checks++; if ({pa, hit} !== {14'h2A00, 1'b0} || wc !== 2) begin errors++;
            $display("FAIL midwalk_cold: got paddr=%h hit=%b walk=%0d expected 2a00/0/2", pa, hit, wc); end
    endtask

`ifdef TLB_STATS_EN
    task automatic test_stats();
        logic hit; logic [13:0] pa, wm; int wc, rc;
        do_reset();
        transact(14'h0100, 14'h1000, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        transact(14'h0100, 14'h0000, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        transact(14'h0101, 14'h0000, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        transact(14'h0200, 14'h2000, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        transact(14'h0200, 14'h0000, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        checks++; if ({out_hit_cnt, out_miss_cnt} !== {16'd3, 16'd2}) begin errors++;
            $display("FAIL stats_counts: got hit=%0d miss=%0d expected 3/2", out_hit_cnt, out_miss_cnt); end
        @(negedge in_clk);
        force dut.hit_cnt_q = 16'hFFFF;
        #1 release dut.hit_cnt_q;
        transact(14'h0200, 14'h0000, 0, 1'b0, 1'b0, hit, pa, wc, rc, wm);
        checks++; if ({out_hit_cnt, out_miss_cnt} !== {16'hFFFF, 16'd2}) begin errors++;
            $display("FAIL stats_saturate: got hit=%h miss=%0d expected ffff/2", out_hit_cnt, out_miss_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss_rehit();
        test_back_to_back();
        test_replacement();
        test_flush();
        test_reset_mid_walk();
`ifdef TLB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
